score_digit_renderer: RTL and testbench

Parametrised multi-digit score renderer for the piano-tiles VGA path. It accepts a binary score and converts it to BCD sequentially using shift-add-3. It then streams one glyph pixel per cycle, with coordinates, colour and plot strobe, straight into the 160x120 `vga_adapter`. It generalises the single-purpose digit drawer: digit count, glyph size, pitch, origin and colours are all parameters, and it adds saturation, leading-zero blanking, a stall input and an explicit done pulse.

---
 rtl/score_render_pkg.sv | 35 +++
 rtl/digit_glyph_rom.sv | 45 ++++
 rtl/score_digit_renderer.sv | 220 ++++++++++++++++++++++
 tb/tb_score_digit_renderer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_render_pkg.sv
// rtl/score_render_pkg.sv - shared types, constants and helpers for the score renderer
package score_render_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DRAW    = 2'd2,
    ST_DONE    = 2'd3
  } render_state_e;

  localparam int DEF_GLYPH_W = 8;
  localparam int DEF_GLYPH_H = 8;

  // Native size of the stored font; other glyph sizes are nearest-neighbour scaled.
  localparam int FONT_DIM = 8;

  localparam logic [2:0] COLOUR_WHITE = 3'b111;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic logic [63:0] sat_limit(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// rtl/digit_glyph_rom.sv - combinational 0-9 glyph bitmap lookup, one pixel per access
module digit_glyph_rom
  import score_render_pkg::*;
#(
  parameter int GLYPH_W = DEF_GLYPH_W,
  parameter int GLYPH_H = DEF_GLYPH_H,
  parameter int ROW_W   = idx_width(GLYPH_H),
  parameter int COL_W   = idx_width(GLYPH_W)
) (
  input  logic [3:0]       digit_i,
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] col_i,
  output logic             pixel_o
);

  logic [63:0] bitmap;
  int          src_row;
  int          src_col;

  // Select the 8x8 bitmap; row 0 is the top byte, column 0 the byte MSB. Codes 10-15 are empty.
  always_comb begin
    bitmap = 64'h0;
    case (digit_i)
      4'd0:    bitmap = 64'h3C666E7666663C00;
      4'd1:    bitmap = 64'h1838181818187E00;
      4'd2:    bitmap = 64'h3C66060C30607E00;
      4'd3:    bitmap = 64'h3C66061C06663C00;
      4'd4:    bitmap = 64'h0C1C3C6C7E0C0C00;
      4'd5:    bitmap = 64'h7E607C0606663C00;
      4'd6:    bitmap = 64'h3C607C6666663C00;
      4'd7:    bitmap = 64'h7E060C1830303000;
      4'd8:    bitmap = 64'h3C66663C66663C00;
      4'd9:    bitmap = 64'h3C66663E060C3800;
      default: bitmap = 64'h0;
    endcase
  end

  // Map the requested glyph cell onto the native font grid and pick the bit.
  always_comb begin
    src_row = (int'(row_i) * FONT_DIM) / GLYPH_H;
    src_col = (int'(col_i) * FONT_DIM) / GLYPH_W;
    pixel_o = bitmap[6'(63 - (src_row * FONT_DIM + src_col))];
  end

endmodule

// File: rtl/score_digit_renderer.sv
// rtl/score_digit_renderer.sv - binary score to BCD conversion and glyph pixel streaming
module score_digit_renderer
  import score_render_pkg::*;
#(
  parameter int         NUM_DIGITS    = 4,
  parameter int         SCORE_W       = 14,
  parameter int         GLYPH_W       = DEF_GLYPH_W,
  parameter int         GLYPH_H       = DEF_GLYPH_H,
  parameter int         DIGIT_PITCH   = 10,
  parameter int         X0            = 0,
  parameter int         Y0            = 0,
  parameter logic [2:0] FG_COLOUR     = COLOUR_WHITE,
  parameter logic [2:0] BG_COLOUR     = COLOUR_BLACK,
  parameter bit         BLANK_LEADING = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic [SCORE_W-1:0]      score,
  output logic                    busy,
  output logic                    done,
  output logic                    pix_plot,
  output logic [7:0]              pix_x,
  output logic [6:0]              pix_y,
  output logic [2:0]              pix_colour,
  output logic [4*NUM_DIGITS-1:0] digits_bcd
);

  localparam int          BCD_W = 4 * NUM_DIGITS;
  localparam int          BIT_W = idx_width(SCORE_W);
  localparam int          DIG_W = idx_width(NUM_DIGITS);
  localparam int          ROW_W = idx_width(GLYPH_H);
  localparam int          COL_W = idx_width(GLYPH_W);
  localparam logic [63:0] SAT_MAX = sat_limit(NUM_DIGITS);

  render_state_e     state_q;
  logic [SCORE_W-1:0] score_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [DIG_W-1:0]   dig_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic               busy_q;
  logic               done_q;
  logic               pix_plot_q;
  logic [7:0]         pix_x_q;
  logic [6:0]         pix_y_q;
  logic [2:0]         pix_colour_q;
  logic [BCD_W-1:0]   digits_bcd_q;

  logic [SCORE_W-1:0]    score_sat;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_d;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zero_above;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic                  glyph_bit;
  logic [7:0]            pix_x_d;
  logic [6:0]            pix_y_d;
  logic [2:0]            pix_colour_d;
  logic                  last_col;
  logic                  last_row;
  logic                  last_dig;

  // Clamp the incoming score to what NUM_DIGITS decimal digits can show.
  always_comb begin
    score_sat = score;
    if (64'(score) > SAT_MAX) begin
      score_sat = SAT_MAX[SCORE_W-1:0];
    end
  end

  // One shift-add-3 step: correct every nibble >= 5, then shift in the next score MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_d    = bcd_adj << 1;
    bcd_d[0] = score_q[SCORE_W-1];
  end

  // Leading-zero blanking walks down from the MS digit; the LS digit always shows.
  always_comb begin
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above   = zero_above && (digits_bcd_q[4*i +: 4] == 4'd0);
      blank_vec[i] = BLANK_LEADING && zero_above && (i != 0);
    end
  end

  // Digit under the draw cursor; dig_q counts screen positions left to right, MS digit first.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(dig_q) == NUM_DIGITS - 1 - i) begin
        cur_digit = digits_bcd_q[4*i +: 4];
        cur_blank = blank_vec[i];
      end
    end
  end

  digit_glyph_rom #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .ROW_W   (ROW_W),
    .COL_W   (COL_W)
  ) u_glyph_rom (
    .digit_i (cur_digit),
    .row_i   (row_q),
    .col_i   (col_q),
    .pixel_o (glyph_bit)
  );

  // Screen coordinate and colour of the pixel under the cursor, truncated to port widths.
  always_comb begin
    pix_x_d      = 8'(X0 + int'(dig_q) * DIGIT_PITCH + int'(col_q));
    pix_y_d      = 7'(Y0 + int'(row_q));
    pix_colour_d = (glyph_bit && !cur_blank) ? FG_COLOUR : BG_COLOUR;
    last_col     = (col_q == COL_W'(GLYPH_W - 1));
    last_row     = (row_q == ROW_W'(GLYPH_H - 1));
    last_dig     = (dig_q == DIG_W'(NUM_DIGITS - 1));
  end

  // Render FSM: accept, convert, stream pixels, pulse done; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      bcd_q        <= '0;
      bit_cnt_q    <= '0;
      dig_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pix_plot_q   <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_colour_q <= BG_COLOUR;
      digits_bcd_q <= '0;
    end else begin
      done_q     <= 1'b0;
      pix_plot_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            score_q   <= score_sat;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (!stall) begin
            bcd_q   <= bcd_d;
            score_q <= score_q << 1;
            if (bit_cnt_q == BIT_W'(SCORE_W - 1)) begin
              digits_bcd_q <= bcd_d;
              dig_q        <= '0;
              row_q        <= '0;
              col_q        <= '0;
              state_q      <= ST_DRAW;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_DRAW: begin
          if (!stall) begin
            pix_plot_q   <= 1'b1;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_colour_q <= pix_colour_d;
            if (!last_col) begin
              col_q <= col_q + 1'b1;
            end else begin
              col_q <= '0;
              if (!last_row) begin
                row_q <= row_q + 1'b1;
              end else begin
                row_q <= '0;
                if (!last_dig) begin
                  dig_q <= dig_q + 1'b1;
                end else begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
                end
              end
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pix_plot   = pix_plot_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_colour = pix_colour_q;
  assign digits_bcd = digits_bcd_q;

endmodule

// File: tb/tb_score_digit_renderer.sv
// tb/tb_score_digit_renderer.sv - randomized self-checking bench for score_digit_renderer
module tb_score_digit_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [13:0] score = '0;
  logic        busy;
  logic        done;
  logic        pix_plot;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;
  logic [15:0] digits_bcd;

  int checks = 0;
  int errors = 0;

  score_digit_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .score      (score),
    .busy       (busy),
    .done       (done),
    .pix_plot   (pix_plot),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_colour (pix_colour),
    .digits_bcd (digits_bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference 8x8 font: row r of digit v, column 0 in the MSB.
  function automatic logic [7:0] font_row(input int v, input int r);
    logic [63:0] g;
    case (v)
      0: g = 64'h3C666E7666663C00;
      1: g = 64'h1838181818187E00;
      2: g = 64'h3C66060C30607E00;
      3: g = 64'h3C66061C06663C00;
      4: g = 64'h0C1C3C6C7E0C0C00;
      5: g = 64'h7E607C0606663C00;
      6: g = 64'h3C607C6666663C00;
      7: g = 64'h7E060C1830303000;
      8: g = 64'h3C66663C66663C00;
      9: g = 64'h3C66663E060C3800;
      default: g = 64'h0;
    endcase
    return g[8*(7-r) +: 8];
  endfunction

  function automatic int pack_pix(input int x, input int y, input int c);
    return (x << 10) | (y << 3) | c;
  endfunction

  // Render one score and compare every output against the decimal model.
  task automatic render(input int sc, input int st_edge, input int st_len,
                        input bit poke_busy, input bit poke_done, input int lim);
    int          pw [4];
    int          exp_q[$];
    int          sat, val, cnt, nplot, fg_low, stall_rem;
    bit          blank, prev_stall;
    logic [7:0]  rowbits;
    logic [15:0] exp_bcd;
    logic [17:0] snap;
    pw = '{1, 10, 100, 1000};
    sat = (sc > 9999) ? 9999 : sc;
    exp_bcd = '0;
    for (int dpos = 0; dpos < 4; dpos++) begin
      int i = 3 - dpos;
      val = (sat / pw[i]) % 10;
      blank = (i != 0) && (sat < pw[i]);
      exp_bcd[4*i +: 4] = 4'(val);
      for (int r = 0; r < 8; r++) begin
        rowbits = font_row(val, r);
        for (int c = 0; c < 8; c++) begin
          exp_q.push_back(pack_pix(dpos * 10 + c, r, (!blank && rowbits[7-c]) ? 7 : 0));
        end
      end
    end

    @(negedge clk);
    score = 14'(sc);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);

    cnt = 0; nplot = 0; fg_low = 0; stall_rem = 0;
    while (cnt < 2000) begin
      snap = {pix_x, pix_y, pix_colour};
      prev_stall = stall;
      @(posedge clk);
      cnt++;
      @(negedge clk);
      start = 1'b0;
      if (prev_stall) begin
        check("stall_plot", pix_plot, 0);
        check("stall_hold", {pix_x, pix_y, pix_colour}, snap);
      end
      if (pix_plot) begin
        if (nplot < exp_q.size())
          check("pix", pack_pix(int'(pix_x), int'(pix_y), int'(pix_colour)), exp_q[nplot]);
        if (pix_colour == 3'b111 && int'(pix_x) < lim) fg_low++;
        nplot++;
      end
      if (done) break;
      if (poke_busy && (cnt == 50 || cnt == 200)) begin
        score = 14'd0;
        start = 1'b1;
      end
      if (cnt == st_edge) stall_rem = st_len;
      if (stall_rem > 0) begin
        stall = 1'b1;
        stall_rem--;
      end else begin
        stall = 1'b0;
      end
    end
    stall = 1'b0;

    check("done_cycle", cnt, 270 + ((st_edge > 0) ? st_len : 0));
    check("plot_count", nplot, 256);
    check("bcd", digits_bcd, exp_bcd);
    if (lim > 0) check("fg_below_lim", fg_low, 0);

    if (poke_done) begin
      score = 14'd1;
      start = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("busy_fall", busy, 0);
    @(posedge clk);
    @(negedge clk);
    check("stay_idle", busy, 0);
  endtask

  // Abort a render at pixel 100 with reset and confirm the block goes quiet.
  task automatic reset_mid_draw();
    int nplot, cnt, late;
    @(negedge clk);
    score = 14'd5678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nplot = 0;
    cnt = 0;
    while (nplot < 100 && cnt < 1000) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
      if (pix_plot) nplot++;
    end
    check("reach_pix100", nplot, 100);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_plot", pix_plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_xy", {pix_x, pix_y, pix_colour}, 18'h0);
    check("rst_bcd", digits_bcd, 0);
    reset = 1'b0;
    late = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (pix_plot || busy) late++;
    end
    check("rst_quiet", late, 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_plot", pix_plot, 0);
    check("reset_x", pix_x, 0);
    check("reset_y", pix_y, 0);
    check("reset_colour", pix_colour, 0);
    check("reset_bcd", digits_bcd, 0);
    reset = 1'b0;
    @(negedge clk);

    render(42, 0, 0, 1'b0, 1'b0, 20);
    render(12345, 0, 0, 1'b0, 1'b0, 0);
    render(0, 0, 0, 1'b0, 1'b0, 30);
    render(42, 120, 5, 1'b0, 1'b0, 20);
    render(9999, 4, 3, 1'b0, 1'b0, 0);
    render(777, 0, 0, 1'b1, 1'b1, 10);
    reset_mid_draw();
    render(9090, 0, 0, 1'b0, 1'b0, 0);
    render(16383, 0, 0, 1'b0, 1'b0, 0);
    render(5, 0, 0, 1'b0, 1'b0, 30);

    for (int n = 0; n < 6; n++) begin
      int sc, se, sl;
      sc = int'($urandom_range(0, 16383));
      se = int'($urandom_range(1, 250));
      sl = int'($urandom_range(0, 6));
      render(sc, se, sl, 1'b0, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
